pc_next_ras: RTL and testbench

Parametrised next-PC generator for the fetch stage of the interrupt-capable RISC pipeline. It selects among reset vector, trap vector, mepc, the stall-held PC, misprediction restore and the BTB prediction. It adds a configurable return-address stack (RAS) for predicted returns, and a vectored trap target computed from mtvec and the interrupt cause. Output feeds the IF-stage PC register.

---
 rtl/pc_next_pkg.sv | 36 +++
 rtl/pc_next_ras_stack.sv | 85 ++++++++
 rtl/pc_next_ras.sv | 166 ++++++++++++++++
 tb/tb_pc_next_ras.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_next_pkg.sv
// ============================================================================
// Module  : pc_next_pkg
// Purpose : Shared encodings for the fetch-stage next-PC generator:
//           pc_src codes, next-PC source select enum, mtvec mode value.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_next_pkg;

  // pc_src encodings driven by the control unit
  localparam logic [1:0] PC_RESET = 2'b00;
  localparam logic [1:0] PC_TRAP  = 2'b01;
  localparam logic [1:0] PC_EPC   = 2'b10;
  localparam logic [1:0] PC_NEXT  = 2'b11;

  // mtvec[1:0] value selecting vectored interrupt dispatch
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Selected next-PC source; the numeric value is the priority rank (1 = highest)
  typedef enum logic [3:0] {
    SEL_NONE    = 4'd0,
    SEL_RESET   = 4'd1,
    SEL_TRAP    = 4'd2,
    SEL_EPC     = 4'd3,
    SEL_HOLD    = 4'd4,
    SEL_STATUS  = 4'd5,
    SEL_RESTORE = 4'd6,
    SEL_RAS     = 4'd7,
    SEL_BTB     = 4'd8,
    SEL_SEQ     = 4'd9
  } pcn_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_ras_stack.sv
// ============================================================================
// Module  : ras_stack
// Purpose : Circular return-address stack. A push when full overwrites the
//           oldest entry; pop+push in one cycle replaces the top entry.
//           Flush has priority over push/pop.
// Ports   : i_clk, i_rst_n      clock, async active-low reset
//           i_flush             clear pointer and count
//           i_push, i_pop       stack operations (pop only when not empty)
//           i_push_data         return address to push
//           o_top               most recently pushed valid entry
//           o_count, o_empty    number of valid entries, count == 0
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [XLEN-1:0]              i_push_data,
  output logic [XLEN-1:0]              o_top,
  output logic [$clog2(RAS_DEPTH):0]   o_count,
  output logic                         o_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] entry_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   top_idx;
  logic            full;

  // ptr points at the next free slot; top is one below it (wraps naturally)
  assign top_idx = ptr_q - PW'(1);
  assign full    = (count_q == CW'(RAS_DEPTH));
  assign o_top   = entry_q[top_idx];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (i_flush) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (i_pop && !i_push) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end else if (i_push && !i_pop) begin
      ptr_d   = ptr_q + PW'(1);
      // saturate: when full the write lands on the oldest slot
      count_d = full ? count_q : count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (!i_flush) begin
        if (i_push && i_pop) begin
          entry_q[top_idx] <= i_push_data;
        end else if (i_push) begin
          entry_q[ptr_q] <= i_push_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_next_ras.sv
// ============================================================================
// Module  : pc_next_ras
// Purpose : Next-PC generator for the fetch stage. Priority mux over reset
//           vector, trap target, mepc, stall-held PC, status-mismatch
//           sequential fetch, misprediction restore, RAS return prediction,
//           BTB prediction and sequential PC. Owns the stall hold register
//           and the return-address stack control.
// Config  : PCNEXT_VECTORED_TRAP_EN - when defined, interrupts taken with
//           mtvec mode 01 dispatch to base + 4*cause.
// Ports   : i_clk, i_rst_n        clock, async active-low reset
//           i_pc_src              00 reset, 01 trap, 10 epc, 11 next
//           i_stall               capture o_nxt_pc for replay next cycle
//           i_mtvec, i_trap_irq, i_trap_cause   trap target inputs
//           i_mepc                exception return PC
//           i_status_if/_ex       pipeline status tags
//           i_restore, i_restore_taken, i_br_pc_real, i_pc_real  EX restore
//           i_pred_pc, i_pred_taken, i_pred_br_pc, i_pred_call, i_pred_ret
//           o_nxt_pc              next fetch PC (combinational)
//           o_sel                 selected source (pcn_sel_e)
//           o_ras_count, o_ras_empty  RAS occupancy
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_next_ras
  import pc_next_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = {XLEN{1'b0}},
  parameter int              RAS_DEPTH  = 4,
  parameter int              ILEN_BYTES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [1:0]                   i_pc_src,
  input  logic                         i_stall,
  input  logic [XLEN-1:0]              i_mtvec,
  input  logic                         i_trap_irq,
  input  logic [4:0]                   i_trap_cause,
  input  logic [XLEN-1:0]              i_mepc,
  input  logic                         i_status_if,
  input  logic                         i_status_ex,
  input  logic                         i_restore,
  input  logic                         i_restore_taken,
  input  logic [XLEN-1:0]              i_br_pc_real,
  input  logic [XLEN-1:0]              i_pc_real,
  input  logic [XLEN-1:0]              i_pred_pc,
  input  logic                         i_pred_taken,
  input  logic [XLEN-1:0]              i_pred_br_pc,
  input  logic                         i_pred_call,
  input  logic                         i_pred_ret,
  output logic [XLEN-1:0]              o_nxt_pc,
  output logic [3:0]                   o_sel,
  output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
  output logic                         o_ras_empty
);

  localparam logic [XLEN-1:0] ILEN = XLEN'(ILEN_BYTES);

  logic            hold_q, hold_d;
  logic [XLEN-1:0] held_pc_q, held_pc_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_flush, ras_push, ras_pop, ras_upd;
  pcn_sel_e        sel;

  assign seq_pc    = i_pred_pc + ILEN;
  assign ret_pc    = i_pred_pc + ILEN;
  assign trap_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef PCNEXT_VECTORED_TRAP_EN
  always_comb begin
    trap_tgt = trap_base;
    if ((i_mtvec[1:0] == MTVEC_VECTORED) && i_trap_irq) begin
      trap_tgt = trap_base + XLEN'({i_trap_cause, 2'b00});
    end
  end
`else
  assign trap_tgt = trap_base;
  logic unused_trap;
  assign unused_trap = ^{i_trap_irq, i_trap_cause, i_mtvec[1:0]};
`endif

  // Priority mux: first match wins
  always_comb begin
    sel      = SEL_SEQ;
    o_nxt_pc = seq_pc;
    if (i_pc_src == PC_RESET) begin
      sel      = SEL_RESET;
      o_nxt_pc = RESET_VEC;
    end else if (i_pc_src == PC_TRAP) begin
      sel      = SEL_TRAP;
      o_nxt_pc = trap_tgt;
    end else if (i_pc_src == PC_EPC) begin
      sel      = SEL_EPC;
      o_nxt_pc = i_mepc;
    end else if (hold_q) begin
      sel      = SEL_HOLD;
      o_nxt_pc = held_pc_q;
    end else if (i_status_if ^ i_status_ex) begin
      sel      = SEL_STATUS;
      o_nxt_pc = seq_pc;
    end else if (i_restore) begin
      sel      = SEL_RESTORE;
      o_nxt_pc = i_restore_taken ? i_br_pc_real : (i_pc_real + ILEN);
    end else if (i_pred_ret && !ras_empty) begin
      sel      = SEL_RAS;
      o_nxt_pc = ras_top;
    end else if (i_pred_taken) begin
      sel      = SEL_BTB;
      o_nxt_pc = i_pred_br_pc;
    end
  end

  assign o_sel = sel;

  // Redirects invalidate speculative call history; hold and status-mismatch
  // cycles leave the stack untouched.
  assign ras_flush = (sel == SEL_RESET) || (sel == SEL_TRAP) ||
                     (sel == SEL_EPC)   || (sel == SEL_RESTORE);
  assign ras_upd   = ((sel == SEL_RAS) || (sel == SEL_BTB) || (sel == SEL_SEQ))
                     && !i_stall;
  assign ras_pop   = ras_upd && (sel == SEL_RAS);
  assign ras_push  = ras_upd && i_pred_call;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (ras_flush),
    .i_push      (ras_push),
    .i_pop       (ras_pop),
    .i_push_data (ret_pc),
    .o_top       (ras_top),
    .o_count     (o_ras_count),
    .o_empty     (ras_empty)
  );

  assign o_ras_empty = ras_empty;

  // Stall replay: the PC chosen in a stalled cycle is re-issued next cycle
  always_comb begin
    hold_d    = i_stall;
    held_pc_d = i_stall ? o_nxt_pc : held_pc_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q    <= 1'b0;
      held_pc_q <= RESET_VEC;
    end else begin
      hold_q    <= hold_d;
      held_pc_q <= held_pc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_next_ras.sv
// ============================================================================
// Module  : tb_pc_next_ras
// Purpose : Self-checking bench for pc_next_ras (default parameters).
//           A queue-based reference model is compared every cycle; directed
//           vectors carry hand-computed literal expectations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_next_ras;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic        stall;
  logic [31:0] mtvec;
  logic        trap_irq;
  logic [4:0]  trap_cause;
  logic [31:0] mepc;
  logic        status_if, status_ex;
  logic        restore, restore_taken;
  logic [31:0] br_pc_real, pc_real;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_br_pc;
  logic        pred_call, pred_ret;
  logic [31:0] nxt_pc;
  logic [3:0]  sel;
  logic [2:0]  ras_count;
  logic        ras_empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_next_ras dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc_src        (pc_src),
    .i_stall         (stall),
    .i_mtvec         (mtvec),
    .i_trap_irq      (trap_irq),
    .i_trap_cause    (trap_cause),
    .i_mepc          (mepc),
    .i_status_if     (status_if),
    .i_status_ex     (status_ex),
    .i_restore       (restore),
    .i_restore_taken (restore_taken),
    .i_br_pc_real    (br_pc_real),
    .i_pc_real       (pc_real),
    .i_pred_pc       (pred_pc),
    .i_pred_taken    (pred_taken),
    .i_pred_br_pc    (pred_br_pc),
    .i_pred_call     (pred_call),
    .i_pred_ret      (pred_ret),
    .o_nxt_pc        (nxt_pc),
    .o_sel           (sel),
    .o_ras_count     (ras_count),
    .o_ras_empty     (ras_empty)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ras[$];
  logic        m_hold = 1'b0;
  logic [31:0] m_held = RVEC;
  bit          model_on = 1'b0;

  function automatic logic [31:0] trap_target();
    logic [31:0] t;
    t = mtvec & ~32'h3;
`ifdef PCNEXT_VECTORED_TRAP_EN
    if (mtvec[1:0] == 2'b01 && trap_irq) t = t + 32'(trap_cause) * 4;
`endif
    return t;
  endfunction

  always @(negedge clk) begin
    int          es;
    logic [31:0] en;
    if (model_on) begin
      if (!rst_n) begin
        m_ras.delete();
        m_hold = 1'b0;
        m_held = RVEC;
      end
      if      (pc_src == 2'b00)              begin es = 1; en = RVEC; end
      else if (pc_src == 2'b01)              begin es = 2; en = trap_target(); end
      else if (pc_src == 2'b10)              begin es = 3; en = mepc; end
      else if (m_hold)                       begin es = 4; en = m_held; end
      else if (status_if != status_ex)       begin es = 5; en = pred_pc + 4; end
      else if (restore)                      begin es = 6; en = restore_taken ? br_pc_real : pc_real + 4; end
      else if (pred_ret && m_ras.size() > 0) begin es = 7; en = m_ras[$]; end
      else if (pred_taken)                   begin es = 8; en = pred_br_pc; end
      else                                   begin es = 9; en = pred_pc + 4; end
      chk("model_nxt_pc", nxt_pc, en);
      chk("model_sel", {28'd0, sel}, 32'(es));
      chk("model_ras_count", {29'd0, ras_count}, 32'(m_ras.size()));
      chk("model_ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      // apply the effect of the coming clock edge
      if (rst_n) begin
        if (es == 1 || es == 2 || es == 3 || es == 6) begin
          m_ras.delete();
        end else if (es >= 7 && !stall) begin
          if (es == 7 && pred_call) m_ras[m_ras.size()-1] = pred_pc + 4;
          else if (es == 7)         void'(m_ras.pop_back());
          else if (pred_call) begin
            m_ras.push_back(pred_pc + 4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
        end
        if (stall) m_held = en;
        m_hold = stall;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic defaults();
    pc_src = 2'b11; stall = 0; mtvec = 32'h0; trap_irq = 0; trap_cause = 0;
    mepc = 0; status_if = 0; status_ex = 0; restore = 0; restore_taken = 0;
    br_pc_real = 0; pc_real = 0; pred_pc = 0; pred_taken = 0; pred_br_pc = 0;
    pred_call = 0; pred_ret = 0;
  endtask

  // advance to just after the next active edge and restore idle inputs
  task automatic next_cycle();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic lit(input string name, input logic [31:0] n, input int s);
    #2;
    chk({name, "_nxt"}, nxt_pc, n);
    chk({name, "_sel"}, {28'd0, sel}, 32'(s));
  endtask

  task automatic call_at(input logic [31:0] pc);
    next_cycle(); pred_pc = pc; pred_call = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    defaults();
    pc_src = 2'b00;
    model_on = 1'b1;
    #3;
    chk("rst_nxt", nxt_pc, 32'h0);
    chk("rst_sel", {28'd0, sel}, 32'd1);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_count", {29'd0, ras_count}, 32'd0);
    next_cycle(); rst_n = 1; pc_src = 2'b00;
    lit("rel_reset", 32'h0, 1);
    next_cycle(); pred_pc = 32'h100;
    lit("seq", 32'h104, 9);

    // trap targets
    next_cycle(); pc_src = 2'b01; mtvec = 32'h1001; trap_irq = 1; trap_cause = 7;
`ifdef PCNEXT_VECTORED_TRAP_EN
    lit("trap_vec", 32'h101C, 2);
`else
    lit("trap_vec", 32'h1000, 2);
`endif
    next_cycle(); pc_src = 2'b01; mtvec = 32'h1001; trap_cause = 7;
    lit("trap_exc", 32'h1000, 2);
    next_cycle(); pc_src = 2'b01; mtvec = 32'h2000; trap_irq = 1; trap_cause = 3;
    lit("trap_direct", 32'h2000, 2);
    next_cycle(); pc_src = 2'b10; mepc = 32'h1234;
    lit("epc", 32'h1234, 3);

    // stall replay
    next_cycle(); pred_pc = 32'h200; stall = 1;
    lit("stall0", 32'h204, 9);
    next_cycle(); pred_pc = 32'h200; stall = 1;
    lit("stall1", 32'h204, 4);
    next_cycle(); pred_pc = 32'h300;
    lit("stall_rel", 32'h204, 4);
    next_cycle(); pred_pc = 32'h300;
    lit("post_stall", 32'h304, 9);

    // calls and returns
    call_at(32'h10); lit("call1", 32'h14, 9);
    call_at(32'h20);
    next_cycle(); pred_pc = 32'h30; pred_ret = 1;
    lit("ret1", 32'h24, 7);
    chk("ret1_count", {29'd0, ras_count}, 32'd2);
    next_cycle(); pred_pc = 32'h40; pred_ret = 1;
    lit("ret2", 32'h14, 7);
    chk("ret2_count", {29'd0, ras_count}, 32'd1);
    next_cycle(); pred_pc = 32'h50; pred_ret = 1;
    lit("ret_empty", 32'h54, 9);

    // overflow: oldest entry lost
    for (int i = 1; i <= 5; i++) call_at(32'(i * 16));
    next_cycle(); pred_pc = 32'h600; pred_ret = 1;
    chk("ovf_count", {29'd0, ras_count}, 32'd4);
    lit("ovf_pop1", 32'h54, 7);
    next_cycle(); pred_pc = 32'h600; pred_ret = 1; lit("ovf_pop2", 32'h44, 7);
    next_cycle(); pred_pc = 32'h600; pred_ret = 1; lit("ovf_pop3", 32'h34, 7);
    next_cycle(); pred_pc = 32'h600; pred_ret = 1; lit("ovf_pop4", 32'h24, 7);
    next_cycle(); pred_pc = 32'h60; pred_ret = 1; lit("ovf_empty", 32'h64, 9);

    // restore flushes RAS
    call_at(32'h10); call_at(32'h20);
    next_cycle(); restore = 1; restore_taken = 1; br_pc_real = 32'h800; pred_ret = 1;
    lit("restore_t", 32'h800, 6);
    next_cycle(); restore = 1; pc_real = 32'h900;
    chk("restore_flush", {29'd0, ras_count}, 32'd0);
    lit("restore_nt", 32'h904, 6);

    // simultaneous pop and push replaces the top
    call_at(32'h10); call_at(32'h20);
    next_cycle(); pred_pc = 32'h60; pred_ret = 1; pred_call = 1;
    lit("poppush", 32'h24, 7);
    next_cycle(); pred_pc = 32'h70; pred_ret = 1;
    chk("poppush_count", {29'd0, ras_count}, 32'd2);
    lit("poppush_top", 32'h64, 7);

    // status mismatch beats restore and RAS; stalled call does not push
    next_cycle(); status_ex = 1; pred_pc = 32'h400; pred_ret = 1; restore = 1;
    lit("status", 32'h404, 5);
    next_cycle(); stall = 1; pred_call = 1; pred_pc = 32'h80;
    lit("stall_call", 32'h84, 9);
    next_cycle(); pred_call = 1; pred_pc = 32'h90;
    chk("stall_nopush", {29'd0, ras_count}, 32'd1);
    lit("stall_call_rep", 32'h84, 4);

    // wrap-around and BTB
    next_cycle(); pred_pc = 32'hFFFF_FFFC; lit("wrap", 32'h0, 9);
    next_cycle(); pred_taken = 1; pred_br_pc = 32'hABC0; lit("btb", 32'hABC0, 8);

    // asynchronous reset mid-stall/mid-push
    call_at(32'h10);
    next_cycle(); stall = 1; pred_call = 1; pred_pc = 32'h30;
    #2; rst_n = 0; #1;
    chk("arst_count", {29'd0, ras_count}, 32'd0);
    chk("arst_empty", {31'd0, ras_empty}, 32'd1);
    next_cycle(); rst_n = 1; pred_pc = 32'h90;
    lit("arst_nohold", 32'h94, 9);
    next_cycle(); pc_src = 2'b00; lit("final_reset", 32'h0, 1);

    next_cycle();
    @(posedge clk);
    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
